// File: rtl/ht_leak_pkg.sv
// Shared definitions for the HT_dynamic_key leakage channel: LFSR seed/width,
// receiver FSM states and the LFSR-to-mask bit mapping.
package ht_leak_pkg;

  localparam int LFSR_W = 20;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 20'h3F364;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } rx_state_e;

  // LFSR bit feeding each mask bit, mask[7] down to mask[0]
  localparam int MASK_SRC_7 = 13;
  localparam int MASK_SRC_6 = 14;
  localparam int MASK_SRC_5 = 15;
  localparam int MASK_SRC_4 = 16;
  localparam int MASK_SRC_3 = 17;
  localparam int MASK_SRC_2 = 18;
  localparam int MASK_SRC_1 = 19;
  localparam int MASK_SRC_0 = 0;

  function automatic logic [7:0] lfsr_to_mask(input logic [LFSR_W-1:0] s);
    return {s[MASK_SRC_7], s[MASK_SRC_6], s[MASK_SRC_5], s[MASK_SRC_4],
            s[MASK_SRC_3], s[MASK_SRC_2], s[MASK_SRC_1], s[MASK_SRC_0]};
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[0], s[19:17], s[16] ^ s[3], s[15], s[14] ^ s[5], s[13],
            s[12] ^ s[7], s[11:1]};
  endfunction

endpackage

// File: rtl/ht_lfsr_mask_gen.sv
// Free-running MOLES LFSR with 8-bit mask tap-out; shared by the trojan
// transmitter and the leakage receiver so both sides stay in lockstep.
module ht_lfsr_mask_gen
  import ht_leak_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] mask
);

  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign mask = lfsr_to_mask(lfsr_q);

endmodule

// File: rtl/ht_key_leak_rx.sv
// Leakage receiver: unmasks the leaked key stream, confirms a candidate over
// CONFIRM matching samples and reports each new key once on a valid/ready port.
// Optional HT_RX_MISMATCH_CNT_EN adds a saturating candidate-mismatch counter.
module ht_key_leak_rx
  import ht_leak_pkg::*;
#(
  parameter int                CONFIRM = 4,
  parameter logic [LFSR_W-1:0] SEED    = SEED_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         key_valid,
  input  logic         key_ready,
  output logic [127:0] key_out,
  output logic         locked
`ifdef HT_RX_MISMATCH_CNT_EN
  ,
  output logic [15:0]  mismatch_cnt
`endif
);

  localparam logic [7:0] CONFIRM_C = 8'(CONFIRM);

  logic [7:0]   mask;
  logic [7:0]   mask_dly_q, mask_dly_d;
  logic [127:0] plain;

  rx_state_e    state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [127:0] cand_q, cand_d;
  logic [127:0] key_out_q, key_out_d;
  logic         key_valid_q, key_valid_d;
  logic         locked_q, locked_d;
  logic         have_last_q, have_last_d;
  logic         mismatch_evt;

  ht_lfsr_mask_gen #(
    .SEED (SEED)
  ) u_mask_gen (
    .clk  (clk),
    .rst  (rst),
    .mask (mask)
  );

  // Transmitter registers its masked output, so its sample lags the mask by one cycle
  assign mask_dly_d = mask;
  assign plain      = in_data ^ {16{mask_dly_q}};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cand_d       = cand_q;
    key_out_d    = key_out_q;
    key_valid_d  = key_valid_q;
    locked_d     = locked_q;
    have_last_d  = have_last_q;
    mismatch_evt = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cand_d  = plain;
          cnt_d   = 8'd1;
          state_d = (CONFIRM_C == 8'd1) ? CHECK : ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (plain == cand_q) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == CONFIRM_C) begin
              state_d = CHECK;
            end
          end else begin
            cand_d       = plain;
            cnt_d        = 8'd1;
            mismatch_evt = 1'b1;
          end
        end
      end
      CHECK: begin
        locked_d = 1'b1;
        if (have_last_q && (cand_q == key_out_q)) begin
          state_d = IDLE;
        end else begin
          key_out_d   = cand_q;
          key_valid_d = 1'b1;
          have_last_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (key_ready) begin
          key_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mask_dly_q  <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_out_q   <= '0;
      key_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      have_last_q <= 1'b0;
    end else begin
      mask_dly_q  <= mask_dly_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_out_q   <= key_out_d;
      key_valid_q <= key_valid_d;
      locked_q    <= locked_d;
      have_last_q <= have_last_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_out   = key_out_q;
  assign locked    = locked_q;

`ifdef HT_RX_MISMATCH_CNT_EN
  logic [15:0] mismatch_cnt_q, mismatch_cnt_d;

  always_comb begin
    mismatch_cnt_d = mismatch_cnt_q;
    if (mismatch_evt && (mismatch_cnt_q != 16'hFFFF)) begin
      mismatch_cnt_d = mismatch_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mismatch_cnt_q <= '0;
    end else begin
      mismatch_cnt_q <= mismatch_cnt_d;
    end
  end

  assign mismatch_cnt = mismatch_cnt_q;
`else
  logic unused_mismatch;
  assign unused_mismatch = mismatch_evt;
`endif

endmodule

// File: tb/tb_ht_key_leak_rx.sv
// Directed bench for ht_key_leak_rx: a behavioural transmitter masks a key
// stream, and the receiver's recovered key, handshake and flags are checked.
module tb_ht_key_leak_rx;

  localparam logic [19:0]  SEED  = 20'h3F364;
  localparam logic [127:0] K1    = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KONES = {128{1'b1}};
  localparam logic [127:0] K2    = 128'hDEADBEEF_0123_4567_89AB_CDEF_5A5A_A5A5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_out;
  logic         locked;
`ifdef HT_RX_MISMATCH_CNT_EN
  logic [15:0]  mismatch_cnt;
`endif

  logic [127:0] key;
  logic [19:0]  tx_lfsr;
  logic [127:0] tx_q;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  always #5 clk = ~clk;

  ht_key_leak_rx #(.CONFIRM(4), .SEED(SEED)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_out   (key_out),
    .locked    (locked)
`ifdef HT_RX_MISMATCH_CNT_EN
    ,
    .mismatch_cnt (mismatch_cnt)
`endif
  );

  // Transmitter model: shift-right LFSR with extra taps, output registered
  function automatic logic [19:0] tx_step(input logic [19:0] s);
    logic [19:0] n;
    n     = s >> 1;
    n[19] = s[0];
    n[15] = n[15] ^ s[3];
    n[13] = n[13] ^ s[5];
    n[11] = n[11] ^ s[7];
    return n;
  endfunction

  function automatic logic [7:0] tx_mask(input logic [19:0] s);
    return {s[13], s[14], s[15], s[16], s[17], s[18], s[19], s[0]};
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      tx_lfsr <= SEED;
      tx_q    <= '0;
    end else begin
      tx_lfsr <= tx_step(tx_lfsr);
      tx_q    <= key ^ {16{tx_mask(tx_lfsr)}};
    end
  end

  assign in_data = tx_q;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    key_ready = 1'b0;
    key       = '0;

    // Reset state
    do_reset();
    check_eq("rst_key_valid", 128'(key_valid), 128'd0);
    check_eq("rst_key_out", key_out, 128'd0);
    check_eq("rst_locked", 128'(locked), 128'd0);
    check_eq("rst_lfsr", 128'(u_dut.u_mask_gen.lfsr_q), 128'(20'h3F364));

    // Key 0: first sample is {16{F8}} and unmasks to 0
    tick();
    check_eq("lfsr_step1", 128'(u_dut.u_mask_gen.lfsr_q), 128'(20'h1D9B2));
    in_valid = 1'b1;
    repeat (4) tick();
    check_eq("k0_not_yet", 128'(key_valid), 128'd0);
    tick();
    check_eq("k0_valid", 128'(key_valid), 128'd1);
    check_eq("k0_key", key_out, 128'd0);
    check_eq("k0_locked", 128'(locked), 128'd1);

    // Handshake, then a different key is reported again
    key_ready = 1'b1;
    in_valid  = 1'b0;
    key       = K1;
    tick();
    check_eq("k0_ack", 128'(key_valid), 128'd0);
    in_valid = 1'b1;
    repeat (4) tick();
    check_eq("k1_not_yet", 128'(key_valid), 128'd0);
    tick();
    check_eq("k1_valid", 128'(key_valid), 128'd1);
    check_eq("k1_key", key_out, K1);
    tick();
    check_eq("k1_ack", 128'(key_valid), 128'd0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (key_valid) pulses++;
    end
    check_eq("k1_no_rereport", 128'(pulses), 128'd0);
    check_eq("k1_key_hold", key_out, K1);

    // Key changes mid-ACCUM
    in_valid  = 1'b0;
    key_ready = 1'b0;
    do_reset();
    tick();
    in_valid = 1'b1;
    tick();
    tick();
    key = KONES;
    tick();
    tick();
    check_eq("chg_after_mm", 128'(key_valid), 128'd0);
`ifdef HT_RX_MISMATCH_CNT_EN
    check_eq("mm_cnt_1", 128'(mismatch_cnt), 128'd1);
`endif
    repeat (3) tick();
    check_eq("chg_not_yet", 128'(key_valid), 128'd0);
    tick();
    check_eq("chg_valid", 128'(key_valid), 128'd1);
    check_eq("chg_key", key_out, KONES);
    check_eq("chg_locked", 128'(locked), 128'd1);

    // Back-pressure in DONE
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("stall_valid", 128'(key_valid), 128'd1);
      check_eq("stall_key", key_out, KONES);
    end
`ifdef HT_RX_MISMATCH_CNT_EN
    check_eq("mm_cnt_hold", 128'(mismatch_cnt), 128'd1);
`endif
    key_ready = 1'b1;
    tick();
    check_eq("stall_ack", 128'(key_valid), 128'd0);

    // Gapped stream: valid on alternate cycles
    in_valid  = 1'b0;
    key_ready = 1'b0;
    key       = K2;
    do_reset();
    tick();
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0);
      tick();
    end
    in_valid = 1'b0;
    check_eq("gap_not_yet", 128'(key_valid), 128'd0);
    tick();
    check_eq("gap_valid", 128'(key_valid), 128'd1);
    check_eq("gap_key", key_out, K2);

    // Reset while DONE with a pending key
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_eq("mid_rst_valid", 128'(key_valid), 128'd0);
    check_eq("mid_rst_key", key_out, 128'd0);
    check_eq("mid_rst_locked", 128'(locked), 128'd0);
    check_eq("mid_rst_lfsr", 128'(u_dut.u_mask_gen.lfsr_q), 128'(20'h3F364));
`ifdef HT_RX_MISMATCH_CNT_EN
    check_eq("mid_rst_mm", 128'(mismatch_cnt), 128'd0);
`endif
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
